// File: rtl/weight_mem.sv
// weight_mem: signed weight store with auto-incrementing load stream and
// zero-latency read port. Define WMEM_PARITY_EN for per-word even parity.
module weight_mem #(
    parameter int  DATA_W   = 16,
    parameter int  N_IN     = 2,
    parameter int  N_HIDDEN = 8,
    localparam int DEPTH    = N_HIDDEN * N_IN,
    localparam int ADDR_W   = $clog2((DEPTH > 1) ? DEPTH : 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done,
    input  logic              engine_busy,
    input  logic [ADDR_W-1:0] wmem_raddr,
    output logic [DATA_W-1:0] wmem_rdata,
    output logic              parity_err
);

`ifdef WMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              rd_ok;

    logic [MEM_W-1:0]  mem_q [DEPTH];

    // Next-state: restart wins over a same-cycle write
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        count_d    = count_q;
        done_d     = done_q;
        wr_en      = 1'b0;
        load_ready = (state_q == LOAD) && !engine_busy;
        if (load_start) begin
            state_d = LOAD;
            waddr_d = '0;
            count_d = '0;
            done_d  = 1'b0;
        end else if (load_ready && load_valid) begin
            wr_en   = 1'b1;
            waddr_d = waddr_q + ADR_ONE;
            count_d = count_q + CNT_ONE;
            if (waddr_q == LAST) begin
                state_d = IDLE;
                waddr_d = '0;
                done_d  = 1'b1;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Weight array: written on each accepted handshake, never reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[waddr_q] <= wr_word;
    end

    assign rd_ok   = done_q && ({1'b0, wmem_raddr} < DEPTH_C);
    assign rd_word = mem_q[wmem_raddr];

    assign wmem_rdata = rd_ok ? rd_word[DATA_W-1:0] : '0;
    assign load_count = count_q;
    assign load_done  = done_q;

`ifdef WMEM_PARITY_EN
    logic perr_q, perr_d;

    assign wr_word = {^load_data, load_data};

    // Sticky error on an odd-parity word read by the busy engine
    always_comb begin
        perr_d = perr_q;
        if (load_start) begin
            perr_d = 1'b0;
        end else if (engine_busy && rd_ok && (^rd_word)) begin
            perr_d = 1'b1;
        end
    end

    // Parity error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`else
    assign wr_word    = load_data;
    assign parity_err = 1'b0;
`endif

endmodule
